// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: size encodings, buffer FSM states and store-entry layout shared by the store buffer
package mips_mem_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;
  // word address kept wide enough for any ADDR_W up to 64; unused upper bits stay zero
  typedef struct packed {
    logic [61:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;
endpackage

// File: rtl/be_gen.sv
// be_gen: byte enables, lane-replicated write data and misalignment flag for a CPU access
module be_gen
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_data,
  output logic        o_misaligned
);
  always_comb begin
    o_be = i_size == SZ_HALF ? (i_addr[1] ? 4'b1100 : 4'b0011) :
           i_size == SZ_BYTE ? 4'b0001 << i_addr : 4'b1111;
    o_data = i_size == SZ_HALF ? {2{i_wdata[15:0]}} :
             i_size == SZ_BYTE ? {4{i_wdata[7:0]}} : i_wdata;
    o_misaligned = i_size == SZ_HALF ? i_addr[0] :
                   i_size == SZ_BYTE ? 1'b0 : i_addr != 2'b00;
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between CPU and memory; loads bypass queued stores unless they hit a buffered word
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  state_t r_state;
  entry_t r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_count;
  logic [3:0] w_be;
  logic [31:0] w_data, w_shift;
  logic w_mis, w_pop, w_full_stall, w_push, w_load, w_match, w_rd_stall;
  be_gen u_be_gen (
    .i_size(size),
    .i_addr(addr[1:0]),
    .i_wdata(wdata),
    .o_be(w_be),
    .o_data(w_data),
    .o_misaligned(w_mis)
  );
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      w_match = w_match | (r_valid[i] && r_mem[i].waddr == 62'(addr[ADDR_W-1:2]));
    w_pop = r_state == WR && mem_ack;
    // a pop in the same cycle frees the slot, so a full buffer still accepts the store
    w_full_stall = memwrite && !w_mis && r_count == (PW+1)'(DEPTH) && !w_pop;
    w_push = memwrite && !w_mis && !w_full_stall;
    w_load = memread && !memwrite && !w_mis;
    w_rd_stall = w_load && r_state != RDONE;
    w_shift = size == SZ_BYTE ? mem_rdata >> {addr[1:0], 3'b000} :
              size == SZ_HALF ? mem_rdata >> {addr[1], 4'b0000} : mem_rdata;
  end
  assign stall = reset && (w_full_stall || w_rd_stall);
  assign misalign = reset && (memwrite || memread) && w_mis;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_valid <= '0;
      rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= '{62'(addr[ADDR_W-1:2]), w_data, w_be};
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_valid <= (r_valid & ~(DEPTH'(w_pop) << r_head)) | (DEPTH'(w_push) << r_tail);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      case (r_state)
        IDLE:
          if (w_load && !w_match) begin
            r_state <= RD;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
          end else if (r_count != '0) begin
            r_state <= WR;
            mem_req <= 1'b1;
            mem_we <= 1'b1;
            mem_addr <= {r_mem[r_head].waddr[ADDR_W-3:0], 2'b00};
            mem_wdata <= r_mem[r_head].data;
            mem_be <= r_mem[r_head].be;
          end
        WR:
          if (mem_ack) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
          end
        RD:
          if (mem_ack) begin
            r_state <= RDONE;
            mem_req <= 1'b0;
            rdata <= w_shift;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store entries (power of two, >=2).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 memwrite  in  1  CPU store request, sampled each cycle.
REQ-006 memread  in  1  CPU load request, held by CPU while stall=1.
REQ-007 size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
REQ-008 addr  in  ADDR_W  byte address (ALU result).
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 rdata  out  32  load data, addressed byte/half shifted to bits [7:0]/[15:0], upper bits of word passed unshifted-above.
REQ-011 stall  out  1  CPU must hold PC and request.
REQ-012 misalign  out  1  one-cycle pulse on dropped misaligned access.
REQ-013 mem_req/mem_we  out  1/1  memory request and write qualifier.
REQ-014 mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=00.
REQ-015 mem_wdata/mem_be  out  32/4  lane-placed write data and byte enables.
REQ-016 mem_ack/mem_rdata  in  1/32  memory completion and read word, valid on ack.

Function
REQ-017 Store encode: word be=1111 data=wdata; half be=addr[1]?1100:0011 data={2{wdata[15:0]}}; byte be=0001<<addr[1:0] data={4{wdata[7:0]}}; little-endian.
REQ-018 Misaligned store/load (word addr[1:0]!=0, half addr[0]=1): not enqueued/issued, stall=0, misalign=1 for that cycle.
REQ-019 Store accepted at clock edge when memwrite=1, stall=0; entry {addr[ADDR_W-1:2], data, be} written at tail, count+1.
REQ-020 Store stall = memwrite && count==DEPTH && !pop_this_cycle; push and pop in same cycle when full are both accepted.
REQ-021 memwrite and memread both 1: store only, load ignored that cycle.
REQ-022 FSM states IDLE, WR, RD, RDONE; reset state IDLE.
REQ-023 IDLE: memread && no word-address match in valid entries -> RD; else count>0 -> WR (loads beat drains).
REQ-024 WR: mem_req=1, mem_we=1, head entry on mem_addr/wdata/be held stable until mem_ack; on ack pop head, -> IDLE.
REQ-025 RD: mem_req=1, mem_we=0, mem_addr={addr[ADDR_W-1:2],2'b00}; on ack capture mem_rdata into rdata register, -> RDONE.
REQ-026 RDONE: stall=0 for exactly one cycle, rdata valid; -> IDLE.
REQ-027 Load stall = memread && state!=RDONE && !misaligned; a load matching a buffered word address waits until those entries drain.
REQ-028 rdata shift: byte -> word>>(8*addr[1:0]); half -> word>>(16*addr[1]); word unshifted; holds value until next RD capture.
REQ-029 Head/tail pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-030 mem_req never deasserts before mem_ack once raised.

Reset
REQ-031 While reset=0 at an edge: state=IDLE, head=tail=count=0, rdata=0, misalign=0, mem_req=0, mem_we=0, mem_addr/mem_wdata=0, mem_be=0000.
REQ-032 Reset mid-transaction discards buffered stores and in-flight request; mem_req=0 from cycle after reset edge; late mem_ack ignored in IDLE.
REQ-033 stall=0 during reset.

Structure
REQ-034 Shared package mips_mem_pkg holds size encoding constants, FSM state enum, and store-entry struct {word address, data, be}.
REQ-035 One combinational sub-module be_gen (size, addr[1:0], wdata -> be, lane data, misaligned) instantiated once.

Verification
REQ-036 Byte store addr=0x13 wdata=0xAB, ack after 2 cycles -> mem_addr=0x10, be=1000, mem_wdata=0xABABABAB, count 1->0.
REQ-037 Five back-to-back word stores, DEPTH=4, mem_ack tied 0 -> stall=1 on fifth; after first ack fifth accepted same cycle, count stays 4.
REQ-038 Load addr=0x22 size=byte, memory word 0x11223344 -> stall until RDONE, rdata[7:0]=0x22, stall=0 one cycle.
REQ-039 Store 0x40 buffered then load 0x40 -> WR first, RD after pop, rdata reflects stored data.
REQ-040 Half store addr=0x05 -> misalign pulse 1 cycle, count unchanged, mem_req stays 0.
REQ-041 reset=0 during WR with 3 entries -> next cycle mem_req=0, count=0, subsequent mem_ack ignored.
